afifo_rd_sched: RTL and testbench

Read-side scheduler that shares one downstream stream between NUM_CH asynchronous FIFOs whose read ports all run on dout_clk. It round-robins among enabled, non-empty channels and drains each granted channel in bursts of up to MAX_BURST words. It drives each FIFO's rd_en, absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, and presents tagged words on a valid/ready interface.

---
 rtl/afifo_rd_sched.sv | 212 +++++++++++++++++++++
 tb/tb_afifo_rd_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_sched.sv
// Round-robin burst scheduler for NUM_CH FIFO read ports sharing dout_clk.
// A 2-entry output buffer absorbs the FIFO's one-cycle registered read latency.
module afifo_rd_sched #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   parameter int CH_W       = $clog2(NUM_CH)
) (
   input  logic                         dout_clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            fifo_empty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
   output logic [NUM_CH-1:0]            fifo_rd_en,
   input  logic [NUM_CH-1:0]            ch_enable,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic                         out_first,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int BC_W  = $clog2(MAX_BURST + 1);
   localparam int ENT_W = DATA_WIDTH + CH_W + 1;
   localparam logic [BC_W-1:0] BURST_LIMIT = BC_W'(MAX_BURST);
   localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state_r;
   logic [CH_W-1:0]       rr_ptr_r;
   logic [CH_W-1:0]       grant_r;
   logic [BC_W-1:0]       burst_cnt_r;
   logic                  inflight_r;
   logic [CH_W-1:0]       inflight_ch_r;
   logic                  inflight_first_r;
   logic [1:0]            buf_cnt_r;
   logic [ENT_W-1:0]      tail_r;

   logic [DATA_WIDTH-1:0] data_arr_s [NUM_CH];
   logic [NUM_CH-1:0]     req_s;
   logic [CH_W-1:0]       cand_s;
   logic [CH_W-1:0]       pick_ch_s;
   logic                  pick_found_s;
   logic                  pop_s;
   logic [2:0]            occ_s;
   logic                  space_s;
   logic                  stop_s;
   logic                  issue_s;
   logic [CH_W-1:0]       next_ptr_s;
   logic [ENT_W-1:0]      push_word_s;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign data_arr_s[g] = fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin pick: first requesting channel at or above rr_ptr_r, wrapping.
   always_comb begin
      req_s        = ch_enable & ~fifo_empty;
      cand_s       = {CH_W{1'b0}};
      pick_ch_s    = rr_ptr_r;
      pick_found_s = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand_s = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
         if (!pick_found_s && req_s[cand_s]) begin
            pick_found_s = 1'b1;
            pick_ch_s    = cand_s;
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Issue decision for the granted channel; a pop this cycle frees a slot now.
   always_comb begin
      pop_s   = out_valid & out_ready;
      occ_s   = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      space_s = (occ_s < 3'd2);
      stop_s  = fifo_empty[grant_r] | ~ch_enable[grant_r] | (burst_cnt_r == BURST_LIMIT);
      if (state_r == BURST) begin
         issue_s = ~fifo_empty[grant_r] & ch_enable[grant_r] &
                   (burst_cnt_r < BURST_LIMIT) & space_s;
      end else begin
         issue_s = 1'b0;
      end
      fifo_rd_en = {NUM_CH{1'b0}};
      if (issue_s) begin
         fifo_rd_en[grant_r] = 1'b1;
      end else begin
         fifo_rd_en = {NUM_CH{1'b0}};
      end
      if (grant_r == LAST_CH) begin
         next_ptr_s = {CH_W{1'b0}};
      end else begin
         next_ptr_s = grant_r + CH_W'(1);
      end
   end

   assign push_word_s = {data_arr_s[inflight_ch_r], inflight_ch_r, inflight_first_r};
   assign busy        = (state_r != IDLE) | inflight_r | (buf_cnt_r != 2'd0);

   // Arbitration FSM: grant latch, burst accounting and round-robin pointer.
   always_ff @(posedge dout_clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         rr_ptr_r    <= {CH_W{1'b0}};
         grant_r     <= {CH_W{1'b0}};
         burst_cnt_r <= {BC_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  grant_r     <= pick_ch_s;
                  burst_cnt_r <= {BC_W{1'b0}};
                  state_r     <= BURST;
               end else begin
                  state_r     <= IDLE;
               end
            end
            BURST: begin
               if (issue_s) begin
                  burst_cnt_r <= burst_cnt_r + BC_W'(1);
               end else if (stop_s) begin
                  // Advances even when the grant issued nothing.
                  state_r  <= IDLE;
                  rr_ptr_r <= next_ptr_s;
               end else begin
                  state_r  <= BURST;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Read-latency tracking: tag of the word the FIFO presents next cycle.
   always_ff @(posedge dout_clk or posedge rst) begin
      if (rst) begin
         inflight_r       <= 1'b0;
         inflight_ch_r    <= {CH_W{1'b0}};
         inflight_first_r <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            inflight_ch_r    <= grant_r;
            inflight_first_r <= (burst_cnt_r == {BC_W{1'b0}});
         end else begin
            inflight_ch_r    <= inflight_ch_r;
            inflight_first_r <= inflight_first_r;
         end
      end
   end

   // Two-entry output buffer whose head is held directly in the output registers.
   always_ff @(posedge dout_clk or posedge rst) begin
      if (rst) begin
         buf_cnt_r <= 2'd0;
         tail_r    <= {ENT_W{1'b0}};
         out_valid <= 1'b0;
         out_data  <= {DATA_WIDTH{1'b0}};
         out_ch    <= {CH_W{1'b0}};
         out_first <= 1'b0;
      end else begin
         case (buf_cnt_r)
            2'd0: begin
               if (inflight_r) begin
                  {out_data, out_ch, out_first} <= push_word_s;
                  out_valid <= 1'b1;
                  buf_cnt_r <= 2'd1;
               end else begin
                  out_valid <= 1'b0;
               end
            end
            2'd1: begin
               if (inflight_r && pop_s) begin
                  {out_data, out_ch, out_first} <= push_word_s;
               end else if (inflight_r) begin
                  tail_r    <= push_word_s;
                  buf_cnt_r <= 2'd2;
               end else if (pop_s) begin
                  out_valid <= 1'b0;
                  buf_cnt_r <= 2'd0;
               end else begin
                  buf_cnt_r <= 2'd1;
               end
            end
            2'd2: begin
               if (pop_s) begin
                  {out_data, out_ch, out_first} <= tail_r;
                  if (inflight_r) begin
                     tail_r <= push_word_s;
                  end else begin
                     buf_cnt_r <= 2'd1;
                  end
               end else begin
                  buf_cnt_r <= 2'd2;
               end
            end
            default: begin
               buf_cnt_r <= 2'd0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_afifo_rd_sched.sv
// Directed bench for afifo_rd_sched: FIFO read-port model, negedge monitor,
// one task per scenario with hand-computed expectations.
module tb_afifo_rd_sched;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int MB  = 4;
   localparam int CW  = 2;

   logic              dout_clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    fifo_empty;
   logic [NCH*DW-1:0] fifo_data;
   logic [NCH-1:0]    fifo_rd_en;
   logic [NCH-1:0]    ch_enable;
   logic [DW-1:0]     out_data;
   logic [CW-1:0]     out_ch;
   logic              out_first;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   int total = 0;
   int bad   = 0;

   always #5 dout_clk = ~dout_clk;

   afifo_rd_sched #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB), .CH_W(CW)) dut (
      .dout_clk  (dout_clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd_en(fifo_rd_en),
      .ch_enable (ch_enable),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_first (out_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // FIFO model: registered read data, empty from pointers
   logic [7:0] mem [NCH][128];
   int         wr_ptr [NCH];
   int         rd_ptr [NCH];
   logic [7:0] dreg [NCH] = '{default: 8'h00};

   always @(posedge dout_clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (fifo_rd_en[i]) begin
            dreg[i]   <= mem[i][rd_ptr[i]];
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_fifo
      assign fifo_empty[g]           = (rd_ptr[g] == wr_ptr[g]);
      assign fifo_data[g*DW +: DW]   = dreg[g];
   end

   // Monitor: transfer log, issue/pop counters, occupancy high-water mark
   int          issued = 0;
   int          popped = 0;
   int          max_out = 0;
   int          onehot_err = 0;
   int          log_n = 0;
   int          rd_cnt [NCH];
   logic [10:0] log_mem [512];

   always @(negedge dout_clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            log_mem[log_n] <= {out_ch, out_first, out_data};
            log_n          <= log_n + 1;
         end
         issued <= issued + int'(fifo_rd_en != 4'd0);
         popped <= popped + int'(out_valid && out_ready);
         if (issued + int'(fifo_rd_en != 4'd0) - popped - int'(out_valid && out_ready) > max_out)
            max_out <= issued + int'(fifo_rd_en != 4'd0) - popped - int'(out_valid && out_ready);
         if ($countones(fifo_rd_en) > 1)
            onehot_err <= onehot_err + 1;
         for (int i = 0; i < NCH; i++) begin
            if (fifo_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge dout_clk);
      #1;
   endtask

   task automatic load(input int ch, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         mem[ch][wr_ptr[ch]] = 8'(int'(base) + k);
         wr_ptr[ch] = wr_ptr[ch] + 1;
      end
   endtask

   task automatic wait_log(input int target, input int budget, input string name);
      for (int c = 0; c < budget && log_n < target; c++) tick();
      total++;
      if (log_n < target) begin
         bad++;
         $display("FAIL %s_timeout got=%0d words want=%0d", name, log_n, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ch_enable = 4'b0000;
      out_ready = 1'b0;
      tick();
      tick();
      total++; if (fifo_rd_en !== 4'b0000) begin bad++; $display("FAIL reset_rd_en got=%b want=0000", fifo_rd_en); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
      total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
      total++; if (out_first !== 1'b0) begin bad++; $display("FAIL reset_first got=%b want=0", out_first); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_single();
      tick();
      ch_enable = 4'b0001;
      mem[0][wr_ptr[0]] = 8'hA1; mem[0][wr_ptr[0]+1] = 8'hB2; mem[0][wr_ptr[0]+2] = 8'hC3;
      wr_ptr[0] = wr_ptr[0] + 3;
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0000) begin bad++; $display("FAIL single_T_rd_en got=%b want=0000", fifo_rd_en); end
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0001) begin bad++; $display("FAIL single_T1_rd_en got=%b want=0001", fifo_rd_en); end
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0001) begin bad++; $display("FAIL single_T2_rd_en got=%b want=0001", fifo_rd_en); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_T2_valid got=%b want=0", out_valid); end
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0001) begin bad++; $display("FAIL single_T3_rd_en got=%b want=0001", fifo_rd_en); end
      total++; if ({out_valid, out_first, out_ch, out_data} !== {1'b1, 1'b1, 2'd0, 8'hA1})
         begin bad++; $display("FAIL single_wordA got=%b/%b/%0d/%h want=1/1/0/a1", out_valid, out_first, out_ch, out_data); end
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0000) begin bad++; $display("FAIL single_T4_rd_en got=%b want=0000", fifo_rd_en); end
      total++; if ({out_valid, out_first, out_ch, out_data} !== {1'b1, 1'b0, 2'd0, 8'hB2})
         begin bad++; $display("FAIL single_wordB got=%b/%b/%0d/%h want=1/0/0/b2", out_valid, out_first, out_ch, out_data); end
      @(negedge dout_clk);
      total++; if ({out_valid, out_first, out_ch, out_data} !== {1'b1, 1'b0, 2'd0, 8'hC3})
         begin bad++; $display("FAIL single_wordC got=%b/%b/%0d/%h want=1/0/0/c3", out_valid, out_first, out_ch, out_data); end
      @(negedge dout_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
      total++; if (dut.rr_ptr_r !== 2'd1) begin bad++; $display("FAIL single_rr_ptr got=%0d want=1", dut.rr_ptr_r); end
      total++; if (rd_cnt[0] !== 3) begin bad++; $display("FAIL single_reads got=%0d want=3", rd_cnt[0]); end
      tick();
      ch_enable = 4'b0000;
   endtask

   task automatic test_burst_limit();
      logic [10:0] exp_l [12];
      int base;
      exp_l = '{{2'd1, 1'b1, 8'h10}, {2'd1, 1'b0, 8'h11}, {2'd1, 1'b0, 8'h12}, {2'd1, 1'b0, 8'h13},
                {2'd2, 1'b1, 8'h20}, {2'd2, 1'b0, 8'h21},
                {2'd1, 1'b1, 8'h14}, {2'd1, 1'b0, 8'h15}, {2'd1, 1'b0, 8'h16}, {2'd1, 1'b0, 8'h17},
                {2'd1, 1'b1, 8'h18}, {2'd1, 1'b0, 8'h19}};
      base = log_n;
      tick();
      load(1, 10, 8'h10);
      load(2, 2, 8'h20);
      ch_enable = 4'b0110;
      wait_log(base + 12, 200, "burst");
      for (int i = 0; i < 12; i++) begin
         total++;
         if (log_mem[base+i] !== exp_l[i]) begin
            bad++; $display("FAIL burst_order[%0d] got=%h want=%h", i, log_mem[base+i], exp_l[i]);
         end
      end
      repeat (4) tick();
      total++; if (dut.rr_ptr_r !== 2'd2) begin bad++; $display("FAIL burst_rr_ptr got=%0d want=2", dut.rr_ptr_r); end
      total++; if (log_n - base !== 12) begin bad++; $display("FAIL burst_count got=%0d want=12", log_n - base); end
      ch_enable = 4'b0000;
   endtask

   task automatic test_fairness();
      logic [10:0] expv;
      int base;
      int ch;
      int k;
      base = log_n;
      tick();
      load(0, 8, 8'h40);
      load(1, 8, 8'h50);
      load(2, 8, 8'h60);
      load(3, 8, 8'h70);
      ch_enable = 4'b1111;
      wait_log(base + 32, 300, "fair");
      // rr_ptr is 2 on entry, so service order is 2,3,0,1,2,3,0,1 in bursts of 4
      for (int i = 0; i < 32; i++) begin
         ch = (2 + i / 4) % 4;
         k = (i / 16) * 4 + (i % 4);
         expv = {2'(ch), (i % 4) == 0, 8'(8'h40 + ch * 16 + k)};
         total++;
         if (log_mem[base+i] !== expv) begin
            bad++; $display("FAIL fair_order[%0d] got=%h want=%h", i, log_mem[base+i], expv);
         end
      end
      repeat (3) tick();
      ch_enable = 4'b0000;
   endtask

   task automatic test_backpressure();
      logic [10:0] exp_l [6];
      int base;
      int snap;
      exp_l = '{{2'd0, 1'b1, 8'h80}, {2'd0, 1'b0, 8'h81}, {2'd0, 1'b0, 8'h82},
                {2'd0, 1'b0, 8'h83}, {2'd0, 1'b1, 8'h84}, {2'd0, 1'b0, 8'h85}};
      base = log_n;
      snap = rd_cnt[0];
      tick();
      load(0, 6, 8'h80);
      ch_enable = 4'b0001;
      for (int c = 0; c < 200 && log_n < base + 6; c++) begin
         out_ready = ((c % 4) == 0);
         tick();
      end
      out_ready = 1'b1;
      repeat (5) tick();
      total++; if (log_n - base !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", log_n - base); end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (log_mem[base+i] !== exp_l[i]) begin
            bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, log_mem[base+i], exp_l[i]);
         end
      end
      total++; if (max_out !== 2) begin bad++; $display("FAIL bp_max_outstanding got=%0d want=2", max_out); end
      total++; if (onehot_err !== 0) begin bad++; $display("FAIL bp_onehot got=%0d want=0", onehot_err); end
      total++; if (rd_cnt[0] - snap !== 6) begin bad++; $display("FAIL bp_reads got=%0d want=6", rd_cnt[0] - snap); end
      ch_enable = 4'b0000;
   endtask

   task automatic test_disable_race();
      int base;
      int snap;
      base = log_n;
      snap = rd_cnt[3];
      tick();
      load(3, 8, 8'h90);
      ch_enable = 4'b1000;
      tick();
      tick();
      tick();
      ch_enable = 4'b0000;
      @(negedge dout_clk);
      total++; if (fifo_rd_en !== 4'b0000) begin bad++; $display("FAIL dis_rd_en got=%b want=0000", fifo_rd_en); end
      repeat (6) tick();
      total++; if (log_n - base !== 2) begin bad++; $display("FAIL dis_count got=%0d want=2", log_n - base); end
      total++; if (log_mem[base] !== {2'd3, 1'b1, 8'h90}) begin bad++; $display("FAIL dis_word0 got=%h want=%h", log_mem[base], {2'd3, 1'b1, 8'h90}); end
      total++; if (log_mem[base+1] !== {2'd3, 1'b0, 8'h91}) begin bad++; $display("FAIL dis_word1 got=%h want=%h", log_mem[base+1], {2'd3, 1'b0, 8'h91}); end
      total++; if (rd_cnt[3] - snap !== 2) begin bad++; $display("FAIL dis_reads got=%0d want=2", rd_cnt[3] - snap); end
      total++; if (dut.rr_ptr_r !== 2'd0) begin bad++; $display("FAIL dis_rr_ptr got=%0d want=0", dut.rr_ptr_r); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_busy got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      int base;
      tick();
      out_ready = 1'b0;
      load(0, 4, 8'hE0);
      ch_enable = 4'b1001;
      repeat (5) tick();
      total++; if (issued - popped !== 2) begin bad++; $display("FAIL rstmid_buffered got=%0d want=2", issued - popped); end
      total++; if ({out_valid, out_data} !== {1'b1, 8'hE0}) begin bad++; $display("FAIL rstmid_head got=%b/%h want=1/e0", out_valid, out_data); end
      rst = 1'b1;
      #2;
      total++; if (fifo_rd_en !== 4'b0000) begin bad++; $display("FAIL rstmid_rd_en got=%b want=0000", fifo_rd_en); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
      total++; if ({out_data, out_ch, out_first} !== {8'h00, 2'd0, 1'b0}) begin bad++; $display("FAIL rstmid_outs got=%h/%0d/%b want=00/0/0", out_data, out_ch, out_first); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      tick();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      base = log_n;
      wait_log(base + 1, 50, "rstmid");
      total++; if (log_mem[base] !== {2'd0, 1'b1, 8'hE2}) begin bad++; $display("FAIL rstmid_first_grant got=%h want=%h", log_mem[base], {2'd0, 1'b1, 8'hE2}); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_burst_limit();
      test_fairness();
      test_backpressure();
      test_disable_race();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
